execute_cycle_md: RTL and testbench

EXECUTE_CYCLE_MD -- requirements
Module: execute_cycle_md

---
 rtl/exec_pkg.sv | 34 +++
 rtl/md_unit.sv | 107 ++++++++++
 rtl/execute_cycle_md.sv | 169 ++++++++++++++++
 tb/tb_execute_cycle_md.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/exec_pkg.sv
// rtl/exec_pkg.sv - shared encodings for the execute stage and its multiply/divide unit
// Purpose : ALU op codes, MD function codes, forward-select codes and MD FSM states.
// Ports   : none (package).
package exec_pkg;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b101
  } alu_op_e;

  typedef enum logic [1:0] {
    MD_MUL   = 2'b00,
    MD_MULHU = 2'b01,
    MD_DIVU  = 2'b10,
    MD_REMU  = 2'b11
  } md_func_e;

  typedef enum logic [1:0] {
    FWD_RD     = 2'b00,
    FWD_W      = 2'b01,
    FWD_M      = 2'b10,
    FWD_RD_ALT = 2'b11
  } fwd_sel_e;

  typedef enum logic [1:0] {
    MD_IDLE = 2'b00,
    MD_BUSY = 2'b01,
    MD_DONE = 2'b10
  } md_state_e;

endpackage

// File: rtl/md_unit.sv
// rtl/md_unit.sv - iterative radix-2 multiply / restoring divide unit
// Purpose : one shift-add (MUL/MULHU) or shift-subtract (DIVU/REMU) step per BUSY cycle.
// Ports   : i_clk, i_rst_n (async active-low), i_start, i_flush, i_func[1:0],
//           i_a/i_b[XLEN] operands -> o_idle, o_busy, o_done, o_result[XLEN].
module md_unit
  import exec_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_start,
  input  logic            i_flush,
  input  logic [1:0]      i_func,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  output logic            o_idle,
  output logic            o_busy,
  output logic            o_done,
  output logic [XLEN-1:0] o_result
);

  localparam int CW = $clog2(XLEN);

  md_state_e       r_state;
  md_state_e       w_next;
  logic [CW-1:0]   r_count;
  logic [1:0]      r_func;
  // r_hi:r_lo is the 2*XLEN product for multiply, remainder:quotient for divide.
  logic [XLEN-1:0] r_hi;
  logic [XLEN-1:0] r_lo;
  logic [XLEN-1:0] r_b;

  logic [XLEN:0]   w_mul_sum;
  logic [XLEN:0]   w_div_sh;
  logic            w_div_ok;
  logic [XLEN-1:0] w_div_rem;
  logic            w_load;
  logic            w_step;

  assign w_load = (r_state == MD_IDLE) && i_start && !i_flush;
  assign w_step = (r_state == MD_BUSY) && !i_flush;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= MD_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      MD_IDLE: if (i_start && !i_flush) w_next = MD_BUSY;
      MD_BUSY: begin
        if (i_flush)              w_next = MD_IDLE;
        else if (r_count == '0)   w_next = MD_DONE;
      end
      MD_DONE: w_next = MD_IDLE;
      default: w_next = MD_IDLE;
    endcase
  end

  // Multiply: add multiplicand into the high half when the current multiplier
  // bit is set, then shift the whole XLEN+1+XLEN value right by one.
  assign w_mul_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);

  // Divide: shift the next dividend bit into the partial remainder and keep the
  // subtraction only if it does not go negative. With a zero divisor every
  // step succeeds, giving an all-ones quotient and the dividend as remainder.
  assign w_div_sh  = {r_hi, r_lo[XLEN-1]};
  assign w_div_ok  = (w_div_sh >= {1'b0, r_b});
  assign w_div_rem = w_div_sh[XLEN-1:0] - r_b;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
      r_func  <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_b     <= '0;
    end else if (w_load) begin
      r_count <= CW'(XLEN - 1);
      r_func  <= i_func;
      r_hi    <= '0;
      r_lo    <= i_a;
      r_b     <= i_b;
    end else if (w_step) begin
      r_count <= r_count - CW'(1);
      if (r_func[1]) begin
        r_hi <= w_div_ok ? w_div_rem : w_div_sh[XLEN-1:0];
        r_lo <= {r_lo[XLEN-2:0], w_div_ok};
      end else begin
        r_hi <= w_mul_sum[XLEN:1];
        r_lo <= {w_mul_sum[0], r_lo[XLEN-1:1]};
      end
    end
  end

  // MUL and DIVU take the low half, MULHU and REMU the high half.
  assign o_result = r_func[0] ? r_hi : r_lo;
  assign o_idle   = (r_state == MD_IDLE);
  assign o_busy   = (r_state == MD_BUSY);
  assign o_done   = (r_state == MD_DONE);

endmodule

// File: rtl/execute_cycle_md.sv
// rtl/execute_cycle_md.sv - pipeline execute stage with forwarding, ALU, branch and iterative MUL/DIV
// Purpose : computes E-stage results, branch decision, and the E/M pipeline register.
// Ports   : clk, rst (async active-low); E-stage controls/operands and forwarding
//           sources in; StallE, PCSrcE, ZeroE, PCTargetE combinational out;
//           RegWriteM, MemWriteM, ResultSrcM, RD_M, ALU_ResultM, WriteDataM, PCPlus4M registered out.
module execute_cycle_md
  import exec_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int RADDR = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             RegWriteE,
  input  logic             MemWriteE,
  input  logic             ALUSrcE,
  input  logic             BranchE,
  input  logic             JumpE,
  input  logic [1:0]       ResultSrcE,
  input  logic [2:0]       ALUControlE,
  input  logic             MDOpE,
  input  logic [1:0]       MDFuncE,
  input  logic [XLEN-1:0]  RD1_E,
  input  logic [XLEN-1:0]  RD2_E,
  input  logic [XLEN-1:0]  Imm_Ext_E,
  input  logic [XLEN-1:0]  PCE,
  input  logic [XLEN-1:0]  PCPlus4E,
  input  logic [RADDR-1:0] RD_E,
  input  logic [XLEN-1:0]  ResultW,
  input  logic [XLEN-1:0]  ALU_ResultM_in,
  input  logic [1:0]       ForwardA_E,
  input  logic [1:0]       ForwardB_E,
  input  logic             FlushE,
  output logic             StallE,
  output logic             PCSrcE,
  output logic             ZeroE,
  output logic [XLEN-1:0]  PCTargetE,
  output logic             RegWriteM,
  output logic             MemWriteM,
  output logic [1:0]       ResultSrcM,
  output logic [RADDR-1:0] RD_M,
  output logic [XLEN-1:0]  ALU_ResultM,
  output logic [XLEN-1:0]  WriteDataM,
  output logic [XLEN-1:0]  PCPlus4M
);

  logic [XLEN-1:0]  w_fwd_a;
  logic [XLEN-1:0]  w_fwd_b;
  logic [XLEN-1:0]  w_src_b;
  logic [XLEN-1:0]  w_alu;
  logic             w_md_idle;
  logic             w_md_busy;
  logic             w_md_done;
  logic             w_md_start;
  logic [XLEN-1:0]  w_md_result;

  // Controls of the MD instruction, held until its result is written to M.
  logic             r_md_regwrite;
  logic             r_md_memwrite;
  logic [1:0]       r_md_resultsrc;
  logic [RADDR-1:0] r_md_rd;
  logic [XLEN-1:0]  r_md_pcplus4;

  always_comb begin
    w_fwd_a = RD1_E;
    case (ForwardA_E)
      FWD_W:   w_fwd_a = ResultW;
      FWD_M:   w_fwd_a = ALU_ResultM_in;
      default: w_fwd_a = RD1_E;
    endcase
  end

  always_comb begin
    w_fwd_b = RD2_E;
    case (ForwardB_E)
      FWD_W:   w_fwd_b = ResultW;
      FWD_M:   w_fwd_b = ALU_ResultM_in;
      default: w_fwd_b = RD2_E;
    endcase
  end

  assign w_src_b = ALUSrcE ? Imm_Ext_E : w_fwd_b;

  always_comb begin
    w_alu = '0;
    case (ALUControlE)
      ALU_ADD: w_alu = w_fwd_a + w_src_b;
      ALU_SUB: w_alu = w_fwd_a - w_src_b;
      ALU_AND: w_alu = w_fwd_a & w_src_b;
      ALU_OR:  w_alu = w_fwd_a | w_src_b;
      ALU_SLT: w_alu = {{(XLEN-1){1'b0}}, ($signed(w_fwd_a) < $signed(w_src_b))};
      default: w_alu = '0;
    endcase
  end

  assign ZeroE     = (w_alu == '0);
  assign PCTargetE = PCE + Imm_Ext_E;

  assign w_md_start = w_md_idle && MDOpE && !FlushE;
  // Reset gates the issue-cycle term so a pending MDOpE cannot raise StallE
  // while the stage is held in reset.
  assign StallE = rst && (w_md_start || w_md_busy);
  assign PCSrcE = ((ZeroE && BranchE) || JumpE) && !FlushE && !StallE;

  md_unit #(
    .XLEN(XLEN)
  ) u_md_unit (
    .i_clk    (clk),
    .i_rst_n  (rst),
    .i_start  (MDOpE),
    .i_flush  (FlushE),
    .i_func   (MDFuncE),
    .i_a      (w_fwd_a),
    .i_b      (w_fwd_b),
    .o_idle   (w_md_idle),
    .o_busy   (w_md_busy),
    .o_done   (w_md_done),
    .o_result (w_md_result)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_md_regwrite  <= 1'b0;
      r_md_memwrite  <= 1'b0;
      r_md_resultsrc <= '0;
      r_md_rd        <= '0;
      r_md_pcplus4   <= '0;
    end else if (w_md_start) begin
      r_md_regwrite  <= RegWriteE;
      r_md_memwrite  <= MemWriteE;
      r_md_resultsrc <= ResultSrcE;
      r_md_rd        <= RD_E;
      r_md_pcplus4   <= PCPlus4E;
    end
  end

  // E/M register. A stall or flush inserts a bubble by clearing only the
  // write enables; flush wins over the MD completion write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      RegWriteM   <= 1'b0;
      MemWriteM   <= 1'b0;
      ResultSrcM  <= '0;
      RD_M        <= '0;
      ALU_ResultM <= '0;
      WriteDataM  <= '0;
      PCPlus4M    <= '0;
    end else if (FlushE || StallE) begin
      RegWriteM <= 1'b0;
      MemWriteM <= 1'b0;
    end else if (w_md_done) begin
      RegWriteM   <= r_md_regwrite;
      MemWriteM   <= r_md_memwrite;
      ResultSrcM  <= r_md_resultsrc;
      RD_M        <= r_md_rd;
      ALU_ResultM <= w_md_result;
      PCPlus4M    <= r_md_pcplus4;
    end else begin
      RegWriteM   <= RegWriteE;
      MemWriteM   <= MemWriteE;
      ResultSrcM  <= ResultSrcE;
      RD_M        <= RD_E;
      ALU_ResultM <= w_alu;
      WriteDataM  <= w_fwd_b;
      PCPlus4M    <= PCPlus4E;
    end
  end

endmodule

// File: tb/tb_execute_cycle_md.sv
// tb/tb_execute_cycle_md.sv - directed self-checking bench for execute_cycle_md
module tb_execute_cycle_md;

  localparam int XLEN  = 32;
  localparam int RADDR = 5;

  logic             clk = 1'b0;
  logic             rst;
  logic             RegWriteE, MemWriteE, ALUSrcE, BranchE, JumpE;
  logic [1:0]       ResultSrcE;
  logic [2:0]       ALUControlE;
  logic             MDOpE;
  logic [1:0]       MDFuncE;
  logic [XLEN-1:0]  RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E;
  logic [RADDR-1:0] RD_E;
  logic [XLEN-1:0]  ResultW, ALU_ResultM_in;
  logic [1:0]       ForwardA_E, ForwardB_E;
  logic             FlushE;
  logic             StallE, PCSrcE, ZeroE;
  logic [XLEN-1:0]  PCTargetE;
  logic             RegWriteM, MemWriteM;
  logic [1:0]       ResultSrcM;
  logic [RADDR-1:0] RD_M;
  logic [XLEN-1:0]  ALU_ResultM, WriteDataM, PCPlus4M;

  int n_chk  = 0;
  int n_fail = 0;

  execute_cycle_md #(.XLEN(XLEN), .RADDR(RADDR)) dut (
    .clk(clk), .rst(rst),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .ALUSrcE(ALUSrcE),
    .BranchE(BranchE), .JumpE(JumpE), .ResultSrcE(ResultSrcE),
    .ALUControlE(ALUControlE), .MDOpE(MDOpE), .MDFuncE(MDFuncE),
    .RD1_E(RD1_E), .RD2_E(RD2_E), .Imm_Ext_E(Imm_Ext_E), .PCE(PCE),
    .PCPlus4E(PCPlus4E), .RD_E(RD_E), .ResultW(ResultW),
    .ALU_ResultM_in(ALU_ResultM_in), .ForwardA_E(ForwardA_E),
    .ForwardB_E(ForwardB_E), .FlushE(FlushE), .StallE(StallE),
    .PCSrcE(PCSrcE), .ZeroE(ZeroE), .PCTargetE(PCTargetE),
    .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
    .RD_M(RD_M), .ALU_ResultM(ALU_ResultM), .WriteDataM(WriteDataM),
    .PCPlus4M(PCPlus4M)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_e;
    RegWriteE = 0; MemWriteE = 0; ALUSrcE = 0; BranchE = 0; JumpE = 0;
    ResultSrcE = 0; ALUControlE = 0; MDOpE = 0; MDFuncE = 0;
    RD1_E = 0; RD2_E = 0; Imm_Ext_E = 0; PCE = 0; PCPlus4E = 0; RD_E = 0;
    ResultW = 0; ALU_ResultM_in = 0; ForwardA_E = 0; ForwardB_E = 0; FlushE = 0;
  endtask

  task automatic start_md(input logic [1:0] func, input logic [31:0] a, input logic [31:0] b);
    clear_e;
    RegWriteE = 1; MDOpE = 1; MDFuncE = func;
    RD1_E = a; RD2_E = b; RD_E = 5'd7; PCPlus4E = 32'h44;
    #1;
  endtask

  task automatic run_md(input string tag, input logic [1:0] func,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
    int cnt;
    bit bad;
    cnt = 0;
    bad = 0;
    start_md(func, a, b);
    while (StallE === 1'b1 && cnt < 100) begin
      cnt++;
      if (cnt > 1 && RegWriteM !== 1'b0) bad = 1;
      tick;
      if (cnt == 1) begin
        // Operands and function must already be latched; disturb the E inputs.
        RD1_E = ~a; RD2_E = a ^ 32'h5A5A_5A5A; MDFuncE = ~func; RD_E = 5'd9;
      end
    end
    chk({tag, " stall cycles"}, cnt, 33);
    chk({tag, " RegWriteM low while stalled"}, {31'd0, bad}, 0);
    chk({tag, " RegWriteM low in DONE"}, {31'd0, RegWriteM}, 0);
    clear_e;
    tick;
    chk({tag, " result"}, ALU_ResultM, exp);
    chk({tag, " RegWriteM"}, {31'd0, RegWriteM}, 1);
    chk({tag, " RD_M"}, {27'd0, RD_M}, 7);
  endtask

  initial begin
    bit bad;
    clear_e;
    rst = 0;
    MDOpE = 1;
    #2;
    chk("reset StallE", {31'd0, StallE}, 0);
    chk("reset RegWriteM", {31'd0, RegWriteM}, 0);
    chk("reset MemWriteM", {31'd0, MemWriteM}, 0);
    chk("reset ALU_ResultM", ALU_ResultM, 0);
    chk("reset RD_M", {27'd0, RD_M}, 0);
    chk("reset WriteDataM", WriteDataM, 0);
    chk("reset PCPlus4M", PCPlus4M, 0);
    MDOpE = 0;
    tick;
    tick;
    rst = 1;
    tick;

    // ADD with A forwarded from M
    clear_e;
    RegWriteE = 1; RD1_E = 5; ForwardA_E = 2'b10; ALU_ResultM_in = 7; RD2_E = 3;
    RD_E = 5'd3; PCPlus4E = 32'h14;
    tick;
    chk("add fwdM result", ALU_ResultM, 10);
    chk("add RegWriteM", {31'd0, RegWriteM}, 1);
    chk("add RD_M", {27'd0, RD_M}, 3);
    chk("add WriteDataM", WriteDataM, 3);
    chk("add PCPlus4M", PCPlus4M, 32'h14);

    // SUB with B forwarded from W
    clear_e;
    RegWriteE = 1; ALUControlE = 3'b001; RD1_E = 5; ForwardB_E = 2'b01; ResultW = 20; RD2_E = 1;
    tick;
    chk("sub fwdW result", ALU_ResultM, 32'hFFFF_FFF1);
    chk("sub WriteDataM", WriteDataM, 20);

    // AND with immediate: WriteDataM carries forwarded B, not the immediate
    clear_e;
    MemWriteE = 1; ResultSrcE = 2'b01; ALUControlE = 3'b010; ALUSrcE = 1;
    RD1_E = 32'hF0F0; Imm_Ext_E = 32'hFF00; RD2_E = 32'h1234; ForwardB_E = 2'b11;
    tick;
    chk("and imm result", ALU_ResultM, 32'hF000);
    chk("and WriteDataM", WriteDataM, 32'h1234);
    chk("and MemWriteM", {31'd0, MemWriteM}, 1);
    chk("and ResultSrcM", {30'd0, ResultSrcM}, 1);

    clear_e;
    ALUControlE = 3'b011; RD1_E = 32'hF0; RD2_E = 32'h0F;
    tick;
    chk("or result", ALU_ResultM, 32'hFF);

    clear_e;
    ALUControlE = 3'b101; RD1_E = 32'hFFFF_FFFF; RD2_E = 1;
    tick;
    chk("slt -1<1", ALU_ResultM, 1);

    clear_e;
    ALUControlE = 3'b101; RD1_E = 1; RD2_E = 32'hFFFF_FFFF;
    #1;
    chk("slt 1<-1 zero", {31'd0, ZeroE}, 1);

    clear_e;
    ALUControlE = 3'b111; RD1_E = 3; RD2_E = 4;
    tick;
    chk("undefined op result", ALU_ResultM, 0);

    // Branch taken on SUB 9-9, then the same with a flush
    clear_e;
    RegWriteE = 1; ALUControlE = 3'b001; RD1_E = 9; RD2_E = 9; BranchE = 1;
    PCE = 32'h100; Imm_Ext_E = 32'h20;
    #1;
    chk("branch ZeroE", {31'd0, ZeroE}, 1);
    chk("branch PCSrcE", {31'd0, PCSrcE}, 1);
    chk("branch PCTargetE", PCTargetE, 32'h120);
    FlushE = 1;
    #1;
    chk("flushed PCSrcE", {31'd0, PCSrcE}, 0);
    tick;
    chk("flush bubble RegWriteM", {31'd0, RegWriteM}, 0);

    clear_e;
    JumpE = 1; RD1_E = 1; PCE = 32'hFFFF_FFF0; Imm_Ext_E = 32'h20;
    #1;
    chk("jump PCSrcE", {31'd0, PCSrcE}, 1);
    chk("PCTargetE wrap", PCTargetE, 32'h10);
    tick;

    run_md("mul", 2'b00, 32'hFFFF_FFFF, 2, 32'hFFFF_FFFE);
    run_md("mulhu", 2'b01, 32'hFFFF_FFFF, 2, 32'h1);
    run_md("divu", 2'b10, 100, 7, 14);
    run_md("remu", 2'b11, 100, 7, 2);
    run_md("divu by 0", 2'b10, 5, 0, 32'hFFFF_FFFF);
    run_md("remu by 0", 2'b11, 5, 0, 5);

    // Flush in BUSY cycle 10
    start_md(2'b10, 100, 7);
    tick;
    repeat (9) tick;
    chk("flush test busy", {31'd0, StallE}, 1);
    FlushE = 1;
    tick;
    clear_e;
    #1;
    chk("after flush StallE", {31'd0, StallE}, 0);
    chk("after flush RegWriteM", {31'd0, RegWriteM}, 0);
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      if (RegWriteM !== 1'b0 || StallE !== 1'b0) bad = 1;
      tick;
    end
    chk("no write after flush", {31'd0, bad}, 0);
    clear_e;
    RegWriteE = 1; RD1_E = 2; RD2_E = 3; RD_E = 5'd4;
    tick;
    chk("add after flush", ALU_ResultM, 5);
    chk("add after flush RegWriteM", {31'd0, RegWriteM}, 1);

    // Reset in BUSY cycle 5
    start_md(2'b10, 100, 7);
    tick;
    repeat (4) tick;
    chk("reset test busy", {31'd0, StallE}, 1);
    clear_e;
    RD1_E = 1;
    rst = 0;
    #1;
    chk("mid reset StallE", {31'd0, StallE}, 0);
    chk("mid reset RegWriteM", {31'd0, RegWriteM}, 0);
    chk("mid reset ALU_ResultM", ALU_ResultM, 0);
    chk("mid reset RD_M", {27'd0, RD_M}, 0);
    chk("mid reset PCPlus4M", PCPlus4M, 0);
    tick;
    rst = 1;
    tick;
    chk("post reset no stall", {31'd0, StallE}, 0);
    run_md("divu after reset", 2'b10, 100, 7, 14);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
